internal_dataflow: RTL and testbench

INTERNAL_DATAFLOW -- requirements
Module: internal_dataflow

---
 rtl/internal_dataflow.sv | 154 +++++++++++++++
 tb/tb_internal_dataflow.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/internal_dataflow.sv
// Datapath for a 6502-style core: four AND-resolved internal buses, the register file,
// a small ALU and the program counter, all steered by a one-hot flag word.
package internal_dataflow_pkg;
  localparam int SET_DB_TO_DATA  = 0;
  localparam int SET_DB_TO_ACC   = 1;
  localparam int SET_DB_TO_PCL   = 2;
  localparam int SET_DB_TO_PCH   = 3;
  localparam int SET_DB_TO_SB    = 4;
  localparam int SET_SB_TO_DB    = 5;
  localparam int SET_SB_TO_ACC   = 6;
  localparam int SET_SB_TO_X     = 7;
  localparam int SET_SB_TO_Y     = 8;
  localparam int SET_SB_TO_SP    = 9;
  localparam int SET_SB_TO_ADD   = 10;
  localparam int SET_SB_TO_ADH   = 11;
  localparam int SET_ADH_TO_SB   = 12;
  localparam int SET_ADH_TO_DATA = 13;
  localparam int SET_ADH_TO_PCH  = 14;
  localparam int SET_ADH_TO_ZERO = 15;
  localparam int SET_ADL_TO_DATA = 16;
  localparam int SET_ADL_TO_PCL  = 17;
  localparam int SET_ADL_TO_SP   = 18;
  localparam int SET_ADL_TO_ADD  = 19;
  localparam int LOAD_ACC        = 20;
  localparam int LOAD_X          = 21;
  localparam int LOAD_Y          = 22;
  localparam int LOAD_SP         = 23;
  localparam int LOAD_ABL        = 24;
  localparam int LOAD_ABH        = 25;
  localparam int LOAD_DOR        = 26;
  localparam int LOAD_PCL        = 27;
  localparam int LOAD_PCH        = 28;
  localparam int LOAD_AI         = 29;
  localparam int LOAD_BI         = 30;
  localparam int LOAD_ADD        = 31;
  localparam int ALU_SUM         = 32;
  localparam int ALU_AND         = 33;
  localparam int ALU_OR          = 34;
  localparam int ALU_XOR         = 35;
  localparam int ALU_SR          = 36;
  localparam int CARRY_IN        = 37;
  localparam int PC_INC          = 38;
endpackage

module internal_dataflow
  import internal_dataflow_pkg::*;
(
  input  logic         clk,
  input  logic         nrst,
  input  logic [100:0] flags,
  input  logic [7:0]   externalDBRead,
  output logic [7:0]   externalDBWrite,
  output logic [7:0]   externalAddressBusLowOutput,
  output logic [7:0]   externalAddressBusHighOutput
);

  logic [7:0] acc_q, x_q, y_q, sp_q, pcl_q, pch_q, abl_q, abh_q, dor_q, ai_q, bi_q, add_q;
  logic [7:0] acc_d, x_d, y_d, sp_d, pcl_d, pch_d, abl_d, abh_d, dor_d, ai_d, bi_d, add_d;
  logic [7:0] db_base, sb_base, adh_base;
  logic [7:0] db_bus, sb_bus, adh_bus, adl_bus;
  logic [7:0] alu_sum, alu_result;
  logic [15:0] pc_next;
  logic unused_flags;

  assign unused_flags = ^flags[100:39];

  // Undriven buses float high, so every driver can simply AND onto 0xFF.
  always_comb begin
    db_base = 8'hFF;
    if (flags[SET_DB_TO_DATA]) db_base &= externalDBRead;
    if (flags[SET_DB_TO_ACC])  db_base &= acc_q;
    if (flags[SET_DB_TO_PCL])  db_base &= pcl_q;
    if (flags[SET_DB_TO_PCH])  db_base &= pch_q;

    sb_base = 8'hFF;
    if (flags[SET_SB_TO_ACC])  sb_base &= acc_q;
    if (flags[SET_SB_TO_X])    sb_base &= x_q;
    if (flags[SET_SB_TO_Y])    sb_base &= y_q;
    if (flags[SET_SB_TO_SP])   sb_base &= sp_q;
    if (flags[SET_SB_TO_ADD])  sb_base &= add_q;

    adh_base = 8'hFF;
    if (flags[SET_ADH_TO_DATA]) adh_base &= externalDBRead;
    if (flags[SET_ADH_TO_PCH])  adh_base &= pch_q;
    if (flags[SET_ADH_TO_ZERO]) adh_base = 8'h00;

    adl_bus = 8'hFF;
    if (flags[SET_ADL_TO_DATA]) adl_bus &= externalDBRead;
    if (flags[SET_ADL_TO_PCL])  adl_bus &= pcl_q;
    if (flags[SET_ADL_TO_SP])   adl_bus &= sp_q;
    if (flags[SET_ADL_TO_ADD])  adl_bus &= add_q;

    // Bus-to-bus links only read the other bus's base value: one hop, no loops.
    sb_bus  = sb_base;
    db_bus  = db_base;
    adh_bus = adh_base;
    if (flags[SET_SB_TO_DB])  sb_bus  &= db_base;
    if (flags[SET_SB_TO_ADH]) sb_bus  &= adh_base;
    if (flags[SET_DB_TO_SB])  db_bus  &= sb_base;
    if (flags[SET_ADH_TO_SB]) adh_bus &= sb_base;
  end

  always_comb begin
    alu_sum    = ai_q + bi_q + {7'b0, flags[CARRY_IN]};
    alu_result = 8'h00;
    if (flags[ALU_SUM])      alu_result = alu_sum;
    else if (flags[ALU_AND]) alu_result = ai_q & bi_q;
    else if (flags[ALU_OR])  alu_result = ai_q | bi_q;
    else if (flags[ALU_XOR]) alu_result = ai_q ^ bi_q;
    else if (flags[ALU_SR])  alu_result = {flags[CARRY_IN], ai_q[7:1]};
  end

  always_comb begin
    pc_next = {pch_q, pcl_q} + 16'd1;
    acc_d = acc_q; x_d = x_q; y_d = y_q; sp_d = sp_q;
    abl_d = abl_q; abh_d = abh_q; dor_d = dor_q;
    ai_d = ai_q; bi_d = bi_q; add_d = add_q;
    pcl_d = pcl_q; pch_d = pch_q;
    // The increment sets the baseline; an explicit byte load then overrides it.
    if (flags[PC_INC]) begin
      pcl_d = pc_next[7:0];
      pch_d = pc_next[15:8];
    end
    if (flags[LOAD_PCL]) pcl_d = adl_bus;
    if (flags[LOAD_PCH]) pch_d = adh_bus;
    if (flags[LOAD_ACC]) acc_d = sb_bus;
    if (flags[LOAD_X])   x_d   = sb_bus;
    if (flags[LOAD_Y])   y_d   = sb_bus;
    if (flags[LOAD_SP])  sp_d  = sb_bus;
    if (flags[LOAD_AI])  ai_d  = sb_bus;
    if (flags[LOAD_ABL]) abl_d = adl_bus;
    if (flags[LOAD_ABH]) abh_d = adh_bus;
    if (flags[LOAD_DOR]) dor_d = db_bus;
    if (flags[LOAD_BI])  bi_d  = db_bus;
    if (flags[LOAD_ADD]) add_d = alu_result;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q <= 8'h00; x_q <= 8'h00; y_q <= 8'h00; sp_q <= 8'h00;
      pcl_q <= 8'h00; pch_q <= 8'h00; abl_q <= 8'h00; abh_q <= 8'h00;
      dor_q <= 8'h00; ai_q <= 8'h00; bi_q <= 8'h00; add_q <= 8'h00;
    end else begin
      acc_q <= acc_d; x_q <= x_d; y_q <= y_d; sp_q <= sp_d;
      pcl_q <= pcl_d; pch_q <= pch_d; abl_q <= abl_d; abh_q <= abh_d;
      dor_q <= dor_d; ai_q <= ai_d; bi_q <= bi_d; add_q <= add_d;
    end
  end

  assign externalDBWrite              = dor_q;
  assign externalAddressBusLowOutput  = abl_q;
  assign externalAddressBusHighOutput = abh_q;

endmodule

// File: tb/tb_internal_dataflow.sv
// Self-checking bench for internal_dataflow: directed scenarios plus randomized flag
// words, all compared against a table-driven model of the bus/register rules.
module tb_internal_dataflow;
  import internal_dataflow_pkg::*;

  logic         clk;
  logic         nrst;
  logic [100:0] flags;
  logic [7:0]   externalDBRead;
  logic [7:0]   externalDBWrite;
  logic [7:0]   externalAddressBusLowOutput;
  logic [7:0]   externalAddressBusHighOutput;

  int total;
  int bad;

  internal_dataflow dut (
    .clk                          (clk),
    .nrst                         (nrst),
    .flags                        (flags),
    .externalDBRead               (externalDBRead),
    .externalDBWrite              (externalDBWrite),
    .externalAddressBusLowOutput  (externalAddressBusLowOutput),
    .externalAddressBusHighOutput (externalAddressBusHighOutput)
  );

  always #5 clk = ~clk;

  // Model register indices; sources 12 and 13 are the data bus input and constant zero.
  localparam int R_ACC = 0, R_X = 1, R_Y = 2, R_SP = 3, R_PCL = 4, R_PCH = 5;
  localparam int R_ABL = 6, R_ABH = 7, R_DOR = 8, R_AI = 9, R_BI = 10, R_ADD = 11;
  localparam int S_DATA = 12, S_ZERO = 13;
  localparam int B_DB = 0, B_SB = 1, B_ADH = 2, B_ADL = 3;

  // {bus, flag, source} for every direct driver
  localparam int DRV[16][3] = '{
    '{B_DB, 0, S_DATA}, '{B_DB, 1, R_ACC}, '{B_DB, 2, R_PCL}, '{B_DB, 3, R_PCH},
    '{B_SB, 6, R_ACC}, '{B_SB, 7, R_X}, '{B_SB, 8, R_Y}, '{B_SB, 9, R_SP},
    '{B_SB, 10, R_ADD}, '{B_ADH, 13, S_DATA}, '{B_ADH, 14, R_PCH}, '{B_ADH, 15, S_ZERO},
    '{B_ADL, 16, S_DATA}, '{B_ADL, 17, R_PCL}, '{B_ADL, 18, R_SP}, '{B_ADL, 19, R_ADD}
  };
  // {flag, destination register, source bus}
  localparam int LDS[11][3] = '{
    '{20, R_ACC, B_SB}, '{21, R_X, B_SB}, '{22, R_Y, B_SB}, '{23, R_SP, B_SB},
    '{29, R_AI, B_SB}, '{24, R_ABL, B_ADL}, '{27, R_PCL, B_ADL}, '{25, R_ABH, B_ADH},
    '{28, R_PCH, B_ADH}, '{26, R_DOR, B_DB}, '{30, R_BI, B_DB}
  };

  logic [7:0] mreg[12];
  logic [7:0] mnext[12];

  function automatic logic [100:0] bit_of(input int i);
    logic [100:0] w;
    w = '0;
    w[i] = 1'b1;
    return w;
  endfunction

  function automatic logic [7:0] src_val(input int s, input logic [7:0] d);
    if (s < 12) return mreg[s];
    if (s == S_DATA) return d;
    return 8'h00;
  endfunction

  task automatic model_step(input logic [100:0] f, input logic [7:0] d, input logic rst_n);
    logic [7:0] base[4];
    logic [7:0] bus[4];
    int sum, pc;
    logic [7:0] alu;
    for (int b = 0; b < 4; b++) base[b] = 8'hFF;
    for (int k = 0; k < 16; k++)
      if (f[DRV[k][1]]) base[DRV[k][0]] = base[DRV[k][0]] & src_val(DRV[k][2], d);
    for (int b = 0; b < 4; b++) bus[b] = base[b];
    if (f[SET_SB_TO_DB])  bus[B_SB]  = bus[B_SB] & base[B_DB];
    if (f[SET_SB_TO_ADH]) bus[B_SB]  = bus[B_SB] & base[B_ADH];
    if (f[SET_DB_TO_SB])  bus[B_DB]  = bus[B_DB] & base[B_SB];
    if (f[SET_ADH_TO_SB]) bus[B_ADH] = bus[B_ADH] & base[B_SB];
    sum = (int'(mreg[R_AI]) + int'(mreg[R_BI]) + (f[CARRY_IN] ? 1 : 0)) % 256;
    if (f[ALU_SUM])      alu = 8'(sum);
    else if (f[ALU_AND]) alu = mreg[R_AI] & mreg[R_BI];
    else if (f[ALU_OR])  alu = mreg[R_AI] | mreg[R_BI];
    else if (f[ALU_XOR]) alu = mreg[R_AI] ^ mreg[R_BI];
    else if (f[ALU_SR])  alu = 8'((int'(mreg[R_AI]) / 2) + (f[CARRY_IN] ? 128 : 0));
    else                 alu = 8'h00;
    for (int r = 0; r < 12; r++) mnext[r] = mreg[r];
    if (f[PC_INC]) begin
      pc = (int'(mreg[R_PCH]) * 256 + int'(mreg[R_PCL]) + 1) % 65536;
      mnext[R_PCL] = 8'(pc % 256);
      mnext[R_PCH] = 8'(pc / 256);
    end
    for (int k = 0; k < 11; k++)
      if (f[LDS[k][0]]) mnext[LDS[k][1]] = bus[LDS[k][2]];
    if (f[LOAD_ADD]) mnext[R_ADD] = alu;
    if (!rst_n) for (int r = 0; r < 12; r++) mnext[r] = 8'h00;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [100:0] f, input logic [7:0] d, input logic rst_n);
    @(negedge clk);
    flags = f;
    externalDBRead = d;
    nrst = rst_n;
    model_step(f, d, rst_n);
    @(posedge clk);
    #1;
    for (int r = 0; r < 12; r++) mreg[r] = mnext[r];
    checkOutput("dor", externalDBWrite, mreg[R_DOR]);
    checkOutput("abl", externalAddressBusLowOutput, mreg[R_ABL]);
    checkOutput("abh", externalAddressBusHighOutput, mreg[R_ABH]);
  endtask

  function automatic logic [100:0] rand_flags();
    logic [127:0] r;
    logic [100:0] f;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    f = r[100:0];
    for (int i = 0; i < 39; i++) f[i] = ($urandom_range(0, 3) == 0);
    return f;
  endfunction

  initial begin
    logic [100:0] rd_dor;
    clk = 1'b0;
    nrst = 1'b0;
    flags = '0;
    externalDBRead = 8'h00;
    total = 0;
    bad = 0;
    for (int r = 0; r < 12; r++) mreg[r] = 8'h00;
    rd_dor = bit_of(SET_DB_TO_ACC) | bit_of(LOAD_DOR);

    // Reset with arbitrary flags for two edges
    applyStimulus(rand_flags(), 8'($urandom), 1'b0);
    applyStimulus(rand_flags(), 8'($urandom), 1'b0);
    checkOutput("rst_dor", externalDBWrite, 8'h00);
    checkOutput("rst_abl", externalAddressBusLowOutput, 8'h00);
    checkOutput("rst_abh", externalAddressBusHighOutput, 8'h00);

    // Load chain
    applyStimulus(bit_of(SET_ADH_TO_DATA) | bit_of(SET_SB_TO_ADH) | bit_of(LOAD_X) |
                  bit_of(LOAD_ABH), 8'hAA, 1'b1);
    checkOutput("chain_abh", externalAddressBusHighOutput, 8'hAA);
    applyStimulus(bit_of(SET_SB_TO_X) | bit_of(LOAD_ACC), 8'h00, 1'b1);
    applyStimulus(rd_dor, 8'h00, 1'b1);
    checkOutput("chain_dor", externalDBWrite, 8'hAA);

    // Bus AND and undriven bus
    applyStimulus(bit_of(SET_DB_TO_DATA) | bit_of(SET_SB_TO_DB) | bit_of(LOAD_X), 8'hF0, 1'b1);
    applyStimulus(bit_of(SET_DB_TO_DATA) | bit_of(SET_SB_TO_DB) | bit_of(LOAD_Y), 8'h3C, 1'b1);
    applyStimulus(bit_of(SET_SB_TO_X) | bit_of(SET_SB_TO_Y) | bit_of(LOAD_ACC), 8'h00, 1'b1);
    applyStimulus(rd_dor, 8'h00, 1'b1);
    checkOutput("and_acc", externalDBWrite, 8'h30);
    applyStimulus(bit_of(LOAD_ACC), 8'h00, 1'b1);
    applyStimulus(rd_dor, 8'h00, 1'b1);
    checkOutput("float_acc", externalDBWrite, 8'hFF);

    // ALU wrap: 0xFF + 0x01 + carry
    applyStimulus(bit_of(LOAD_AI), 8'h00, 1'b1);
    applyStimulus(bit_of(SET_DB_TO_DATA) | bit_of(LOAD_BI), 8'h01, 1'b1);
    applyStimulus(bit_of(ALU_SUM) | bit_of(CARRY_IN) | bit_of(LOAD_ADD), 8'h00, 1'b1);
    applyStimulus(bit_of(SET_ADL_TO_ADD) | bit_of(LOAD_ABL), 8'h00, 1'b1);
    checkOutput("alu_abl", externalAddressBusLowOutput, 8'h01);

    // PC wrap and byte-load priority
    applyStimulus(bit_of(SET_ADH_TO_DATA) | bit_of(SET_ADL_TO_DATA) | bit_of(LOAD_PCH) |
                  bit_of(LOAD_PCL), 8'hFF, 1'b1);
    applyStimulus(bit_of(PC_INC), 8'h00, 1'b1);
    applyStimulus(bit_of(SET_ADL_TO_PCL) | bit_of(SET_ADH_TO_PCH) | bit_of(LOAD_ABL) |
                  bit_of(LOAD_ABH), 8'h00, 1'b1);
    checkOutput("pcwrap_l", externalAddressBusLowOutput, 8'h00);
    checkOutput("pcwrap_h", externalAddressBusHighOutput, 8'h00);
    applyStimulus(bit_of(SET_ADL_TO_DATA) | bit_of(LOAD_PCL), 8'h10, 1'b1);
    applyStimulus(bit_of(SET_ADH_TO_DATA) | bit_of(LOAD_PCH), 8'h12, 1'b1);
    applyStimulus(bit_of(PC_INC) | bit_of(SET_ADL_TO_DATA) | bit_of(LOAD_PCL), 8'h55, 1'b1);
    applyStimulus(bit_of(SET_ADL_TO_PCL) | bit_of(SET_ADH_TO_PCH) | bit_of(LOAD_ABL) |
                  bit_of(LOAD_ABH), 8'h00, 1'b1);
    checkOutput("pcload_l", externalAddressBusLowOutput, 8'h55);
    checkOutput("pcload_h", externalAddressBusHighOutput, 8'h12);

    // Reset beats a pending load
    applyStimulus(bit_of(SET_DB_TO_DATA) | bit_of(LOAD_DOR), 8'h11, 1'b1);
    checkOutput("pre_rst_dor", externalDBWrite, 8'h11);
    applyStimulus(bit_of(SET_DB_TO_DATA) | bit_of(LOAD_DOR), 8'h77, 1'b0);
    checkOutput("rstprio_dor", externalDBWrite, 8'h00);

    for (int n = 0; n < 400; n++)
      applyStimulus(rand_flags(), 8'($urandom), ($urandom_range(0, 19) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
